// File: rtl/stopwatch_pkg.sv
// Shared constants and state encoding for the stopwatch minutes:seconds counter.
// Digit limits are fixed: BCD ones 0..9, tens 0..5.
package stopwatch_pkg;

    localparam int TENS_W = 3;
    localparam int ONES_W = 4;

    localparam logic [TENS_W-1:0] TENS_MAX = 3'd5;
    localparam logic [ONES_W-1:0] ONES_MAX = 4'd9;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_PAUSED = 1'b1
    } run_state_t;

endpackage

// File: rtl/bcd_mod60.sv
// Two-digit BCD modulo-60 counter field; steps once per cycle that en is high.
// carry flags the terminal value 59 so the owner can chain or detect a wrap.
module bcd_mod60
    import stopwatch_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic [TENS_W-1:0] tens,
    output logic [ONES_W-1:0] ones,
    output logic              carry
);

    logic              ones_roll;
    logic [ONES_W-1:0] ones_next;
    logic [TENS_W-1:0] tens_next;

    assign ones_roll = (ones == ONES_MAX);
    assign carry     = (tens == TENS_MAX) && ones_roll;

    // An out-of-range digit is forced to 0 on the next step; only a genuine
    // 9 -> 0 rollover of the ones digit advances the tens digit.
    always_comb begin
        ones_next = (ones >= ONES_MAX) ? '0 : ones + 4'd1;
        tens_next = tens;
        if (tens > TENS_MAX) begin
            tens_next = '0;
        end else if (ones_roll) begin
            tens_next = (tens == TENS_MAX) ? '0 : tens + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tens <= '0;
            ones <= '0;
        end else if (en) begin
            tens <= tens_next;
            ones <= ones_next;
        end
    end

endmodule

// File: rtl/stopwatch_counter.sv
// BCD mm:ss stopwatch counter with run/pause control, 1 Hz normal counting,
// 2 Hz per-field adjust, and a one-cycle wrap pulse on 59:59 -> 00:00.
module stopwatch_counter
    import stopwatch_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              tick1Hz,
    input  logic              tick2Hz,
    input  logic              adj,
    input  logic              sel,
    input  logic              pauseReq,
    output logic [TENS_W-1:0] m10,
    output logic [ONES_W-1:0] m1,
    output logic [TENS_W-1:0] s10,
    output logic [ONES_W-1:0] s1,
    output logic              paused,
    output logic              wrap
);

    run_state_t state;

    logic running;
    logic normal_step;
    logic adjust_step;
    logic sec_en;
    logic min_en;
    logic sec_carry;
    logic min_carry;

    // Ticks are qualified by the pre-toggle state, so a pause request in the
    // same cycle as a tick still lets that tick count when leaving RUN.
    assign running     = (state == ST_RUN);
    assign normal_step = running && !adj && tick1Hz;
    assign adjust_step = running &&  adj && tick2Hz;

    assign sec_en = normal_step || (adjust_step && sel);
    assign min_en = (normal_step && sec_carry) || (adjust_step && !sel);

    bcd_mod60 u_seconds (
        .clk   (clk),
        .rst   (rst),
        .en    (sec_en),
        .tens  (s10),
        .ones  (s1),
        .carry (sec_carry)
    );

    bcd_mod60 u_minutes (
        .clk   (clk),
        .rst   (rst),
        .en    (min_en),
        .tens  (m10),
        .ones  (m1),
        .carry (min_carry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_RUN;
            paused <= 1'b0;
            wrap   <= 1'b0;
        end else begin
            wrap <= normal_step && sec_carry && min_carry;
            if (pauseReq) begin
                case (state)
                    ST_RUN: begin
                        state  <= ST_PAUSED;
                        paused <= 1'b1;
                    end
                    default: begin
                        state  <= ST_RUN;
                        paused <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/stopwatch_counter.md
# stopwatch_counter

BCD minutes:seconds counter that feeds the stopwatch 7-segment display stage with `m10`, `m1`, `s10` and `s1`. It advances once per 1 Hz enable in normal mode. In adjust mode it advances the selected field once per 2 Hz enable, with no carry between fields. It owns the run/pause state and the 59:59 wrap. The block runs on the single system clock; the 1 Hz and 2 Hz rates arrive as one-cycle enable pulses from the clock divider.

## Interface
- No parameters; digit limits are fixed constants (see Structure).
- `clk` in 1 — system clock; all state updates on its rising edge.
- `rst` in 1 — synchronous, active-high reset; forces 00:00 and the RUN state.
- `tick1Hz` in 1 — one-cycle enable; normal-mode count step.
- `tick2Hz` in 1 — one-cycle enable; adjust-mode count step.
- `adj` in 1 — level; 1 = adjust mode.
- `sel` in 1 — level; in adjust mode, 1 = seconds field, 0 = minutes field.
- `pauseReq` in 1 — one-cycle pulse, already debounced and edge-detected upstream; toggles run/pause.
- `m10` out 3 — minutes tens, 0..5.
- `m1` out 4 — minutes ones, 0..9.
- `s10` out 3 — seconds tens, 0..5.
- `s1` out 4 — seconds ones, 0..9.
- `paused` out 1 — 1 while in the PAUSED state.
- `wrap` out 1 — one-cycle pulse when the normal-mode count wraps from 59:59 to 00:00.

## Operation
- State machine has two states, RUN and PAUSED. Reset state is RUN.
  - RUN → PAUSED on `pauseReq`.
  - PAUSED → RUN on `pauseReq`.
- PAUSED freezes all four digits, in both normal and adjust mode.
- Normal mode: RUN, `adj`=0, `tick1Hz`=1.
  - Seconds step +1 in BCD.
  - Seconds 59 → 00 carries +1 into minutes.
  - Minutes 59 → 00 with seconds carry gives 00:00 and asserts `wrap`.
- Adjust mode: RUN, `adj`=1, `tick2Hz`=1.
  - `sel`=1: seconds +1, 59 → 00, no carry into minutes.
  - `sel`=0: minutes +1, 59 → 00, seconds unchanged.
  - `tick1Hz` is ignored in adjust mode. `wrap` never asserts in adjust mode.
- `tick2Hz` is ignored in normal mode.
- Digit arithmetic:
  - Ones digit 9 → 0 carries into tens.
  - Tens digit 5 → 0 carries out of the field.
  - Out-of-range values never occur. If forced, the next step loads 0 into that digit.
- Changes of `adj` and `sel` take effect on the next enable; no state is kept across mode changes.

## Timing
- All outputs are registered.
- Digits and `wrap` update on the clock edge where the enabling tick is sampled, so they are visible one cycle after the tick is presented.
- `paused` updates on the edge that samples `pauseReq`.
- Simultaneous events:
  - `pauseReq` and a tick in the same cycle: the tick is qualified by the current (pre-toggle) state. From RUN the count advances and the block then pauses. From PAUSED the count does not advance.
  - `tick1Hz` and `tick2Hz` in the same cycle: only the one matching the current mode acts.
  - `rst` overrides every other input in the same cycle.
- Reset values: `m10`=0, `m1`=0, `s10`=0, `s1`=0, `paused`=0, `wrap`=0.
- Reset mid-adjust or mid-pause returns the block to RUN at 00:00.

## Structure
- Shared package `stopwatch_pkg` holds:
  - `ONES_MAX`=9 and `TENS_MAX`=5.
  - Digit widths: 3 for tens, 4 for ones.
  - The RUN/PAUSED state encoding.
- Sub-module `bcd_mod60`:
  - Two-digit BCD counter with `en` input, `carry` output and `tens`/`ones` outputs.
  - Instantiated twice, once for seconds and once for minutes.
  - The top level generates each instance's `en`: tick qualifier in adjust mode; tick qualifier gated by the seconds `carry` for minutes in normal mode.
- `wrap` = normal-mode step AND seconds `carry` AND minutes `carry`, registered.

## Test plan
- Reset, then 61 `tick1Hz` pulses with `adj`=0 → digits read 01:01; `paused`=0 throughout.
- Preload to 59:59 via adjust mode, then `adj`=0 and one `tick1Hz` → 00:00 and `wrap` high for exactly one cycle.
- `adj`=1, `sel`=1, seconds=59, minutes=07, one `tick2Hz` → seconds 00, minutes stay 07; `tick1Hz` pulses in adjust mode change nothing.
- `pauseReq`, then 10 `tick1Hz` → count frozen and `paused`=1. Second `pauseReq`, then 3 ticks → count +3 and `paused`=0.
- `pauseReq` and `tick1Hz` in the same cycle from RUN at 00:05 → 00:06 and `paused`=1. Repeat from PAUSED → count unchanged and `paused`=0.
- Assert `rst` during adjust mode while PAUSED at 34:12 → next cycle 00:00, `paused`=0, `wrap`=0.
